// File: rtl/mem_io_pkg.sv
// Shared constants for the CPU byte-bus responder: IO decode and byte lanes.
package mem_io_pkg;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [31:0] w,
                                             input logic [1:0]  lane);
        logic [7:0] b;
        b = w[7:0];
        unique case (lane)
            LANE_B0: b = w[7:0];
            LANE_B1: b = w[15:8];
            LANE_B2: b = w[23:16];
            LANE_B3: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_io_tx_fifo.sv
// Synchronous TX byte FIFO; pushes into a full FIFO and pops from empty are dropped.
module mem_io_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        count   = wr_q - rd_q;
        empty   = (count == '0);
        full    = (count == (AW+1)'(DEPTH));
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wr_d    = wr_q + {{AW{1'b0}}, push_ok};
        rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
        count_nxt = wr_d - rd_d;
        pop_data  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM, UART TX queue, UART RX port, cycle counter, halt.
// Optional RX path enabled by defining MEM_IO_RX_EN.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        halt
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]        ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] ram_idx;
    logic              ram_we;
    logic [17:0]       off;
    logic              io_sel;

    logic [7:0]  cpu_din_q, cpu_din_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic        halt_q, halt_d;
    logic        stop_q, stop_d;
    logic        iofull_q, iofull_d;

    logic          push;
    logic [7:0]    push_data;
    logic          pop;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_nxt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          rx_pop_c;
    logic          rx_hit;
    logic [7:0]    rx_byte;

`ifdef MEM_IO_RX_EN
    assign rx_hit  = rx_valid;
    assign rx_byte = rx_valid ? rx_data : 8'h00;
`else
    logic unused_rx;
    assign rx_hit    = 1'b0;
    assign rx_byte   = 8'h00;
    assign unused_rx = ^{rx_data, rx_valid};
`endif

    logic unused_bits;
    assign unused_bits = ^{cpu_a[31:18], fifo_count};

    assign off     = cpu_a[17:0];
    assign io_sel  = (off[17:16] == IO_SEL);
    assign ram_idx = cpu_a[ADDR_W-1:0];

    always_comb begin
        cpu_din_d  = cpu_din_q;
        snapshot_d = snapshot_q;
        halt_d     = halt_q;
        stop_d     = stop_q;
        counter_d  = halt_q ? counter_q : counter_q + 32'd1;
        ram_we     = 1'b0;
        push       = 1'b0;
        push_data  = 8'h00;
        rx_pop_c   = 1'b0;

        if (!cpu_wr) begin
            if (!io_sel) begin
                cpu_din_d = ram_q[ram_idx];
            end else begin
                unique case (1'b1)
                    (off == IO_UART): begin
                        cpu_din_d = rx_byte;
                        rx_pop_c  = rx_hit;
                    end
                    (off[17:2] == IO_CLK[17:2]): begin
                        if (off[1:0] == LANE_B0) begin
                            snapshot_d = counter_q;
                            cpu_din_d  = counter_q[7:0];
                        end else begin
                            cpu_din_d = lane_byte(snapshot_q, off[1:0]);
                        end
                    end
                    default: cpu_din_d = 8'h00;
                endcase
            end
        end else if (!halt_q) begin
            if (!io_sel) begin
                ram_we = 1'b1;
            end else if (off == IO_UART) begin
                push      = (cpu_dout != 8'h00);
                push_data = cpu_dout;
            end else if (off == IO_CLK) begin
                halt_d    = 1'b1;
                push      = 1'b1;
                push_data = 8'h00;
                stop_d    = fifo_full;
            end
        end

        // Deferred stop marker retries until the queue has room.
        if (stop_q) begin
            push      = 1'b1;
            push_data = 8'h00;
            stop_d    = fifo_full;
        end

        iofull_d = (fifo_count_nxt >= CW'(TX_DEPTH - FULL_MARGIN));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cpu_din_q  <= 8'h00;
            counter_q  <= 32'h0;
            snapshot_q <= 32'h0;
            halt_q     <= 1'b0;
            stop_q     <= 1'b0;
            iofull_q   <= 1'b0;
        end else begin
            cpu_din_q  <= cpu_din_d;
            counter_q  <= counter_d;
            snapshot_q <= snapshot_d;
            halt_q     <= halt_d;
            stop_q     <= stop_d;
            iofull_q   <= iofull_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_q[ram_idx] <= cpu_dout;
        end
    end

    mem_io_tx_fifo #(
        .DEPTH  (TX_DEPTH),
        .DATA_W (8)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pop            = tx_valid && tx_ready;
    assign tx_valid       = !fifo_empty;
    assign tx_data        = fifo_data;
    assign cpu_din        = cpu_din_q;
    assign io_buffer_full = iofull_q;
    assign halt           = halt_q;
    assign rx_pop         = rx_pop_c && rst_n_in;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized self-checking bench for mem_io_responder against a queue-based model.
module tb_mem_io_responder;

    localparam int TX_DEPTH    = 8;
    localparam int FULL_MARGIN = 2;
`ifdef MEM_IO_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        halt;

    mem_io_responder #(
        .ADDR_W      (17),
        .TX_DEPTH    (TX_DEPTH),
        .FULL_MARGIN (FULL_MARGIN)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .halt           (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  tx_m[$];
    logic [7:0]  ram_m[int];
    logic [31:0] waddr[$];
    logic [7:0]  dut_emit[$];
    bit          halt_m;
    bit          stop_m;
    int unsigned cnt_m;
    int unsigned snap_m;
    logic [7:0]  din_m;
    int          nvec;
    int          nerr;

    task automatic step(input logic [31:0] a, input logic [7:0] d,
                        input logic wr, input logic txr);
        logic [17:0] off;
        bit io, full_pre, halt_pre, stop_pre, do_push, do_pop;
        logic [7:0] pb;
        cpu_a = a; cpu_dout = d; cpu_wr = wr; tx_ready = txr;
        off = a[17:0];
        io = (off[17:16] == 2'b11);
        full_pre = (tx_m.size() >= TX_DEPTH);
        halt_pre = halt_m;
        stop_pre = stop_m;
        do_pop = txr && (tx_m.size() > 0);
        do_push = 0; pb = 8'h00;
        if (tx_valid && txr) dut_emit.push_back(tx_data);
        if (!wr) begin
            if (!io) din_m = ram_m[int'(a[16:0])];
            else if (off == 18'h30000) din_m = (RX_EN && rx_valid) ? rx_data : 8'h00;
            else if (off == 18'h30004) begin snap_m = cnt_m; din_m = cnt_m[7:0]; end
            else if (off >= 18'h30005 && off <= 18'h30007)
                din_m = 8'(snap_m >> (8 * int'(off - 18'h30004)));
            else din_m = 8'h00;
        end else if (!halt_pre) begin
            if (!io) ram_m[int'(a[16:0])] = d;
            else if (off == 18'h30000 && d != 8'h00) begin do_push = 1; pb = d; end
            else if (off == 18'h30004) begin
                halt_m = 1;
                if (full_pre) stop_m = 1;
                else begin do_push = 1; pb = 8'h00; end
            end
        end
        if (stop_pre && !full_pre) begin do_push = 1; pb = 8'h00; stop_m = 0; end
        if (full_pre) do_push = 0;
        if (!halt_pre) cnt_m++;
        if (do_pop) void'(tx_m.pop_front());
        if (do_push) tx_m.push_back(pb);
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic txr);
        step(32'h0000_0123, 8'h00, 1'b0, txr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_a = 32'h0003_0000; cpu_wr = 1'b0; cpu_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (cpu_din !== 8'h00) begin nerr++; $display("FAIL reset_din got %h want 00", cpu_din); end
        nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL reset_full got %b want 0", io_buffer_full); end
        nvec++; if (halt !== 1'b0) begin nerr++; $display("FAIL reset_halt got %b want 0", halt); end
        nvec++; if (rx_pop !== 1'b0) begin nerr++; $display("FAIL reset_rx_pop got %b want 0", rx_pop); end
        rx_valid = 1'b0; rx_data = 8'h00; cpu_a = 32'h0;
        tx_m.delete(); halt_m = 0; stop_m = 0; cnt_m = 0; snap_m = 0; din_m = 8'h00;
        rst_n = 1'b1;
    endtask

    task automatic test_ram();
        logic [31:0] a;
        logic [7:0]  d;
        step(32'h0000_0123, 8'hA5, 1'b1, 1'b0);
        waddr.push_back(32'h0000_0123);
        nvec++; if (cpu_din !== 8'h00) begin nerr++; $display("FAIL ram_hold got %h want 00", cpu_din); end
        step(32'h0000_0123, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== 8'hA5) begin nerr++; $display("FAIL ram_a5 got %h want a5", cpu_din); end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = {14'h0, 2'($urandom_range(0, 2)), 16'($urandom)};
                d = 8'($urandom);
                waddr.push_back(a);
                step(a, d, 1'b1, 1'b0);
            end else begin
                a = waddr[$urandom_range(0, waddr.size() - 1)];
                step(a, 8'h00, 1'b0, 1'b0);
            end
            nvec++;
            if (cpu_din !== din_m) begin
                nerr++; $display("FAIL ram_rand a=%h got %h want %h", a, cpu_din, din_m);
            end
        end
    endtask

    task automatic test_tx_order();
        dut_emit.delete();
        step(32'h0003_0000, 8'h48, 1'b1, 1'b1);
        step(32'h0003_0000, 8'h69, 1'b1, 1'b1);
        step(32'h0003_0000, 8'h00, 1'b1, 1'b1);
        repeat (6) idle(1'b1);
        nvec++; if (dut_emit.size() != 2) begin nerr++; $display("FAIL tx_order_len got %0d want 2", dut_emit.size()); end
        else begin
            nvec++; if (dut_emit[0] !== 8'h48) begin nerr++; $display("FAIL tx_order_0 got %h want 48", dut_emit[0]); end
            nvec++; if (dut_emit[1] !== 8'h69) begin nerr++; $display("FAIL tx_order_1 got %h want 69", dut_emit[1]); end
        end
        nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL tx_order_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_full();
        logic [7:0] exp_b[$];
        logic [7:0] b;
        repeat (10) idle(1'b1);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(1, 255));
            exp_b.push_back(b);
            step(32'h0003_0000, b, 1'b1, 1'b0);
            if (i == 4) begin
                nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL full_after5 got %b want 0", io_buffer_full); end
            end
            if (i == 5) begin
                nvec++; if (io_buffer_full !== 1'b1) begin nerr++; $display("FAIL full_after6 got %b want 1", io_buffer_full); end
            end
        end
        nvec++; if (tx_data !== exp_b[0]) begin nerr++; $display("FAIL full_head got %h want %h", tx_data, exp_b[0]); end
        dut_emit.delete();
        repeat (12) idle(1'b1);
        nvec++; if (dut_emit.size() != 8) begin nerr++; $display("FAIL full_drain_len got %0d want 8", dut_emit.size()); end
        else begin
            for (int k = 0; k < 8; k++) begin
                nvec++;
                if (dut_emit[k] !== exp_b[k]) begin
                    nerr++; $display("FAIL full_drain_%0d got %h want %h", k, dut_emit[k], exp_b[k]);
                end
            end
        end
        nvec++; if (io_buffer_full !== 1'b0) begin nerr++; $display("FAIL full_clear got %b want 0", io_buffer_full); end
    endtask

    task automatic test_snapshot();
        logic [31:0] got;
        int unsigned want;
        while (cnt_m < 100) idle(1'b0);
        want = cnt_m;
        step(32'h0003_0004, 8'h00, 1'b0, 1'b0);
        got[7:0] = cpu_din;
        repeat (3) idle(1'b0);
        step(32'h0003_0005, 8'h00, 1'b0, 1'b0); got[15:8]  = cpu_din;
        step(32'h0003_0006, 8'h00, 1'b0, 1'b0); got[23:16] = cpu_din;
        idle(1'b0);
        step(32'h0003_0007, 8'h00, 1'b0, 1'b0); got[31:24] = cpu_din;
        nvec++; if (got !== want) begin nerr++; $display("FAIL snapshot got %h want %h", got, want); end
    endtask

    task automatic test_rx();
        logic [7:0] want;
        want = RX_EN ? 8'h41 : 8'h00;
        rx_valid = 1'b1; rx_data = 8'h41;
        cpu_a = 32'h0003_0000; cpu_wr = 1'b0;
        #1;
        nvec++; if (rx_pop !== RX_EN) begin nerr++; $display("FAIL rx_pop got %b want %b", rx_pop, RX_EN); end
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== want) begin nerr++; $display("FAIL rx_data got %h want %h", cpu_din, want); end
        idle(1'b0);
        nvec++; if (rx_pop !== 1'b0) begin nerr++; $display("FAIL rx_pop_pulse got %b want 0", rx_pop); end
        rx_valid = 1'b0;
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== 8'h00) begin nerr++; $display("FAIL rx_empty got %h want 00", cpu_din); end
        step(32'h0003_0010, 8'h77, 1'b1, 1'b0);
        step(32'h0003_0010, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== 8'h00) begin nerr++; $display("FAIL io_other_rd got %h want 00", cpu_din); end
        nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL io_other_wr got %b want 0", tx_valid); end
        rx_data = 8'h00;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  d;
        logic        wr;
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'($urandom);
            rx_data = 8'($urandom);
            wr = 1'b0; d = 8'h00;
            case ($urandom_range(0, 4))
                0: begin
                    a = {14'h0, 2'($urandom_range(0, 2)), 16'($urandom)};
                    d = 8'($urandom); wr = 1'b1; waddr.push_back(a);
                end
                1: a = waddr[$urandom_range(0, waddr.size() - 1)];
                2: begin
                    a = 32'h0003_0000; wr = 1'b1;
                    d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                end
                3: a = 32'h0003_0000;
                default: begin
                    a = 32'h0003_0004 + 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 5) == 0) begin
                        a = 32'h0003_0008; wr = 1'($urandom); d = 8'($urandom);
                    end
                end
            endcase
            step(a, d, wr, 1'($urandom));
            nvec++;
            if (cpu_din !== din_m) begin nerr++; $display("FAIL rand_din a=%h got %h want %h", a, cpu_din, din_m); end
            nvec++;
            if (tx_valid !== (tx_m.size() != 0)) begin
                nerr++; $display("FAIL rand_tx_valid got %b want %b", tx_valid, tx_m.size() != 0);
            end
            if (tx_m.size() != 0) begin
                nvec++;
                if (tx_data !== tx_m[0]) begin nerr++; $display("FAIL rand_tx_data got %h want %h", tx_data, tx_m[0]); end
            end
            nvec++;
            if (io_buffer_full !== (tx_m.size() >= TX_DEPTH - FULL_MARGIN)) begin
                nerr++; $display("FAIL rand_full got %b want %b", io_buffer_full, tx_m.size() >= TX_DEPTH - FULL_MARGIN);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_halt();
        logic [7:0] exp_b[$];
        logic [7:0] b;
        logic [7:0] frozen;
        step(32'h0000_0055, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(1, 255));
            exp_b.push_back(b);
            step(32'h0003_0000, b, 1'b1, 1'b0);
        end
        exp_b.push_back(8'h00);
        nvec++; if (io_buffer_full !== 1'b1) begin nerr++; $display("FAIL halt_prefill got %b want 1", io_buffer_full); end
        step(32'h0003_0004, 8'h01, 1'b1, 1'b0);
        nvec++; if (halt !== 1'b1) begin nerr++; $display("FAIL halt_set got %b want 1", halt); end
        step(32'h0000_0055, 8'hC3, 1'b1, 1'b0);
        step(32'h0003_0000, 8'h77, 1'b1, 1'b0);
        step(32'h0000_0055, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== 8'h3C) begin nerr++; $display("FAIL halt_ram_wr got %h want 3c", cpu_din); end
        step(32'h0003_0004, 8'h00, 1'b0, 1'b0);
        frozen = din_m;
        repeat (3) idle(1'b0);
        step(32'h0003_0004, 8'h00, 1'b0, 1'b0);
        nvec++; if (cpu_din !== frozen) begin nerr++; $display("FAIL halt_cnt_frozen got %h want %h", cpu_din, frozen); end
        dut_emit.delete();
        repeat (14) idle(1'b1);
        nvec++; if (dut_emit.size() != 9) begin nerr++; $display("FAIL halt_drain_len got %0d want 9", dut_emit.size()); end
        else begin
            for (int k = 0; k < 9; k++) begin
                nvec++;
                if (dut_emit[k] !== exp_b[k]) begin
                    nerr++; $display("FAIL halt_drain_%0d got %h want %h", k, dut_emit[k], exp_b[k]);
                end
            end
        end
        nvec++; if (halt !== 1'b1) begin nerr++; $display("FAIL halt_sticky got %b want 1", halt); end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        test_reset();
        test_ram();
        test_tx_order();
        test_full();
        test_snapshot();
        test_rx();
        test_random();
        for (int i = 0; i < 4; i++) step(32'h0003_0000, 8'($urandom_range(1, 255)), 1'b1, 1'b0);
        test_reset();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
